// File: rtl/uart_debug_streamer.sv
// Periodic UART 8N1 dumper of a wide data word (MSB byte first), with an
// optional command receiver built only when DEBUGGER_CMD_RX_EN is defined.
module uart_debug_streamer #(
    parameter int unsigned DATA_WIDTH              = 8320,
    parameter int unsigned DATA_WIDTH_BASE2        = 14,
    parameter int unsigned DIVIDER_TICKS           = 727273,
    parameter int unsigned DIVIDER_TICKS_WIDTH     = 20,
    parameter int unsigned UART_TICKS_PER_BIT      = 139,
    parameter int unsigned UART_TICKS_PER_BIT_SIZE = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  debug_uart_rx_in,
    output logic [7:0]            debug_command,
    output logic                  debug_command_pulse,
    output logic                  debug_command_busy,
    output logic                  tx_out
);

    localparam logic [DATA_WIDTH_BASE2-1:0] BYTES =
        DATA_WIDTH_BASE2'(DATA_WIDTH / 8);
    localparam logic [DIVIDER_TICKS_WIDTH-1:0] DIV_TC =
        DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
    localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] BIT_TC =
        UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t                            r_tx_state;
    tx_state_t                            w_tx_next;
    logic [DIVIDER_TICKS_WIDTH-1:0]       r_div;
    logic [DATA_WIDTH-1:0]                r_shift;
    logic [DATA_WIDTH_BASE2-1:0]          r_byte_cnt;
    logic [2:0]                           r_bit_idx;
    logic [UART_TICKS_PER_BIT_SIZE-1:0]   r_tx_baud;
    logic                                 r_tx_out;
    logic                                 w_div_tc;
    logic                                 w_trigger;
    logic                                 w_tx_baud_done;
    logic                                 w_tx_bit;
    logic [7:0]                           w_cur_byte;

    assign w_div_tc       = (r_div == DIV_TC);
    assign w_trigger      = w_div_tc && (r_tx_state == TX_IDLE);
    assign w_tx_baud_done = (r_tx_baud == BIT_TC);
    assign w_cur_byte     = r_shift[DATA_WIDTH-1 -: 8];
    assign tx_out         = r_tx_out;

    // Free-running divider; terminal counts seen while busy are simply lost.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_div_tc) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIVIDER_TICKS_WIDTH'(1);
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_bit  = 1'b1;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (w_trigger) w_tx_next = TX_START;
            end
            TX_START: begin
                w_tx_bit = 1'b0;
                if (w_tx_baud_done) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_tx_bit = w_cur_byte[r_bit_idx];
                if (w_tx_baud_done && (r_bit_idx == 3'd7)) w_tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (w_tx_baud_done)
                    w_tx_next = (r_byte_cnt > DATA_WIDTH_BASE2'(1)) ? TX_START : TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // Line is registered from the current state, so it lags the state by one clock.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_out   <= w_tx_bit;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx_baud  <= '0;
        end else begin
            if (w_trigger) begin
                r_shift    <= data_in;
                r_byte_cnt <= BYTES;
            end else if ((r_tx_state == TX_STOP) && w_tx_baud_done) begin
                r_shift    <= {r_shift[DATA_WIDTH-9:0], 8'h00};
                r_byte_cnt <= r_byte_cnt - DATA_WIDTH_BASE2'(1);
            end

            if ((r_tx_state == TX_IDLE) || w_tx_baud_done) begin
                r_tx_baud <= '0;
            end else begin
                r_tx_baud <= r_tx_baud + UART_TICKS_PER_BIT_SIZE'(1);
            end

            if (r_tx_state != TX_DATA) begin
                r_bit_idx <= '0;
            end else if (w_tx_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

`ifdef DEBUGGER_CMD_RX_EN
    localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] RX_HALF =
        UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t                            r_rx_state;
    rx_state_t                            w_rx_next;
    logic                                 r_rx_s1;
    logic                                 r_rx_s2;
    logic                                 r_rx_prev;
    logic [UART_TICKS_PER_BIT_SIZE-1:0]   r_rx_baud;
    logic [2:0]                           r_rx_bit_idx;
    logic [7:0]                           r_rx_shift;
    logic [7:0]                           r_cmd;
    logic                                 r_cmd_pulse;
    logic                                 w_rx_fall;
    logic                                 w_rx_baud_done;
    logic                                 w_rx_baud_clr;
    logic                                 w_rx_load;

    assign w_rx_fall      = r_rx_prev && !r_rx_s2;
    assign w_rx_baud_done = (r_rx_baud == BIT_TC);

    assign debug_command       = r_cmd;
    assign debug_command_pulse = r_cmd_pulse;
    assign debug_command_busy  = (r_rx_state == RX_START) ||
                                 (r_rx_state == RX_DATA)  ||
                                 (r_rx_state == RX_STOP);

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_load     = 1'b0;
        w_rx_baud_clr = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_rx_baud_clr = 1'b1;
                if (w_rx_fall) w_rx_next = RX_START;
            end
            RX_START: begin
                if (r_rx_baud == RX_HALF) begin
                    w_rx_baud_clr = 1'b1;
                    w_rx_next     = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                w_rx_baud_clr = w_rx_baud_done;
                if (w_rx_baud_done && (r_rx_bit_idx == 3'd7)) w_rx_next = RX_STOP;
            end
            RX_STOP: begin
                w_rx_baud_clr = w_rx_baud_done;
                if (w_rx_baud_done) begin
                    w_rx_load = r_rx_s2;
                    w_rx_next = r_rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                w_rx_baud_clr = 1'b1;
                if (r_rx_s2) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // Synchroniser flops reset high so a line already low at release reads as one edge.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_baud    <= '0;
            r_rx_bit_idx <= '0;
            r_rx_shift   <= '0;
            r_cmd        <= '0;
            r_cmd_pulse  <= 1'b0;
        end else begin
            r_rx_s1     <= debug_uart_rx_in;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_cmd_pulse <= w_rx_load;

            if (w_rx_baud_clr) begin
                r_rx_baud <= '0;
            end else begin
                r_rx_baud <= r_rx_baud + UART_TICKS_PER_BIT_SIZE'(1);
            end

            if (r_rx_state != RX_DATA) begin
                r_rx_bit_idx <= '0;
            end else if (w_rx_baud_done) begin
                r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                r_rx_shift   <= {r_rx_s2, r_rx_shift[7:1]};
            end

            if (w_rx_load) r_cmd <= r_rx_shift;
        end
    end
`else
    logic w_unused_rx;
    assign w_unused_rx         = debug_uart_rx_in;
    assign debug_command       = 8'h00;
    assign debug_command_pulse = 1'b0;
    assign debug_command_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_debug_streamer.sv
// Directed bench for uart_debug_streamer: a bit-level UART decoder on tx_out
// checked against a byte scoreboard, plus command-receiver checks.
module tb_uart_debug_streamer;

    localparam int unsigned DW     = 16;
    localparam int unsigned DT     = 15;
    localparam int unsigned TPB    = 4;
    // An 80-clock dump drops five terminal counts; the sixth (90 clocks on) triggers.
    localparam int unsigned PERIOD = 90;
`ifdef DEBUGGER_CMD_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          debug_uart_rx_in;
    logic [7:0]    debug_command;
    logic          debug_command_pulse;
    logic          debug_command_busy;
    logic          tx_out;

    uart_debug_streamer #(
        .DATA_WIDTH              (DW),
        .DATA_WIDTH_BASE2        (5),
        .DIVIDER_TICKS           (DT),
        .DIVIDER_TICKS_WIDTH     (4),
        .UART_TICKS_PER_BIT      (TPB),
        .UART_TICKS_PER_BIT_SIZE (3)
    ) dut (
        .clk_in              (clk_in),
        .reset               (reset),
        .data_in             (data_in),
        .debug_uart_rx_in    (debug_uart_rx_in),
        .debug_command       (debug_command),
        .debug_command_pulse (debug_command_pulse),
        .debug_command_busy  (debug_command_busy),
        .tx_out              (tx_out)
    );

    always #5 clk_in = ~clk_in;

    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int   pulse_cnt = 0;
    int   busy_rise = 0;
    logic busy_q    = 1'b0;
    always @(negedge clk_in) begin
        if (debug_command_pulse === 1'b1) pulse_cnt++;
        if (debug_command_busy === 1'b1 && busy_q !== 1'b1) busy_rise++;
        busy_q = debug_command_busy;
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        int unsigned budget = 2000;
        while (cyc < target && budget > 0) begin
            step(1);
            budget--;
        end
        if (cyc != target) check("wait_until", cyc, target);
    endtask

    function automatic int unsigned next_start(input int unsigned rel, input int unsigned now);
        int unsigned t = rel + DT;
        while (t <= now + 2) t += PERIOD;
        return t + 1;
    endfunction

    // Finds a start bit, samples each bit mid-way, compares with the scoreboard.
    task automatic recv_byte(input string tag, output int unsigned s_cyc);
        int unsigned budget = 300;
        bit          found  = 1'b0;
        logic [7:0]  b;
        logic [7:0]  exp;
        logic        stopb;
        while (!found && budget > 0) begin
            step(1);
            budget--;
            if (tx_out === 1'b0) found = 1'b1;
        end
        s_cyc = cyc;
        check({tag, "_start_seen"}, 32'(found), 32'd1);
        if (found) begin
            step(2);
            for (int i = 0; i < 8; i++) begin
                step(TPB);
                b[i] = tx_out;
            end
            step(TPB);
            stopb = tx_out;
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            check({tag, "_byte"}, 32'(b), 32'(exp));
            check({tag, "_stop"}, 32'(stopb), 32'd1);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        debug_uart_rx_in = 1'b0;
        step(TPB);
        for (int i = 0; i < 8; i++) begin
            debug_uart_rx_in = b[i];
            step(TPB);
            if (i == 3) check("rx_busy_mid", 32'(debug_command_busy), 32'(RX_EN));
        end
        debug_uart_rx_in = 1'b1;
        step(TPB);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=stuck required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned rel, s0, s1, ns;
        int          p0, r0;

        reset = 1'b0;
        debug_uart_rx_in = 1'b1;
        data_in = 16'h4c09;
        step(3);
        check("rst_tx", 32'(tx_out), 32'd1);
        check("rst_cmd", 32'(debug_command), 32'd0);
        check("rst_pulse", 32'(debug_command_pulse), 32'd0);
        check("rst_busy", 32'(debug_command_busy), 32'd0);

        @(negedge clk_in);
        reset = 1'b1;
        rel = cyc;

        // Dump 0, with data_in changed between the two bytes.
        sb.push_back(8'h4c);
        sb.push_back(8'h09);
        recv_byte("d0b0", s0);
        check("d0_first_start", s0 - rel, 32'd16);
        data_in = 16'hFFFF;
        recv_byte("d0b1", s1);
        check("d0_no_gap", s1 - s0, 32'd40);

        // Dump 1: the terminal counts during dump 0 must not be queued.
        sb.push_back(8'hFF);
        sb.push_back(8'hFF);
        recv_byte("d1b0", s0);
        check("d1_start", s0 - rel, 32'd106);
        recv_byte("d1b1", s1);

        data_in = 16'h81A5;
        sb.push_back(8'h81);
        sb.push_back(8'hA5);
        ns = next_start(rel, cyc);
        wait_until(ns - 2);
        recv_byte("d2b0", s0);
        check("d2_start", s0, ns);
        recv_byte("d2b1", s1);

        // Command frame 0x5A.
        p0 = pulse_cnt;
        r0 = busy_rise;
        send_rx(8'h5A);
        step(10);
        check("rx_pulse_count", 32'(pulse_cnt - p0), 32'(RX_EN));
        check("rx_cmd", 32'(debug_command), RX_EN ? 32'h5A : 32'h00);
        check("rx_busy_after", 32'(debug_command_busy), 32'd0);
        check("rx_busy_frames", 32'(busy_rise - r0), 32'(RX_EN));

        // Command line stuck low while a dump runs.
        p0 = pulse_cnt;
        r0 = busy_rise;
        debug_uart_rx_in = 1'b0;
        data_in = 16'h6D12;
        sb.push_back(8'h6D);
        sb.push_back(8'h12);
        ns = next_start(rel, cyc);
        wait_until(ns - 2);
        recv_byte("d3b0", s0);
        check("d3_start", s0, ns);
        recv_byte("d3b1", s1);
        step(10);
        check("low_busy", 32'(debug_command_busy), 32'd0);
        check("low_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("low_frames", 32'(busy_rise - r0), 32'(RX_EN));
        debug_uart_rx_in = 1'b1;

        // Reset in the middle of a data bit that drives the line low.
        ns = next_start(rel, cyc);
        wait_until(ns + 9);
        check("pre_reset_tx", 32'(tx_out), 32'd0);
        reset = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx_out), 32'd1);
        data_in = 16'hC35A;
        sb.push_back(8'hC3);
        sb.push_back(8'h5A);
        step(3);
        @(negedge clk_in);
        reset = 1'b1;
        rel = cyc;
        recv_byte("d4b0", s0);
        check("d4_start", s0 - rel, 32'd16);
        recv_byte("d4b1", s1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_debug_streamer.md
Name: uart_debug_streamer

Overview:
- Periodic debug dumper. Every DIVIDER_TICKS clocks it snapshots a wide data word and sends it out as a stream of UART 8N1 bytes, most-significant byte first.
- Optionally receives single-byte commands on a separate UART input and presents each one with a one-cycle strobe.
- Sits beside the LED-panel controller. It is also used standalone as a bulk serial data transmitter (frame source) at the controller's RX baud.

Parameters:
- DATA_WIDTH, 8320: width of data_in in bits; must be a multiple of 8.
- DATA_WIDTH_BASE2, 14: width of the internal bit/byte index counters; must satisfy 2^DATA_WIDTH_BASE2 > DATA_WIDTH.
- DIVIDER_TICKS, 727273: clocks between dump triggers.
- DIVIDER_TICKS_WIDTH, 20: width of the divider counter.
- UART_TICKS_PER_BIT, 139: clocks per UART bit, used for both TX and RX.
- UART_TICKS_PER_BIT_SIZE, 8: width of the baud counters.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  word to dump; sampled only at trigger.
- debug_uart_rx_in  input  1  command UART line, asynchronous, idle high.
- debug_command  output  8  last valid received command byte.
- debug_command_pulse  output  1  one-cycle strobe when debug_command updates.
- debug_command_busy  output  1  high while a command frame is being received.
- tx_out  output  1  dump UART line, idle high.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - tx_out=1, debug_command=0, debug_command_pulse=0, debug_command_busy=0.
  - All counters to 0; TX state IDLE; RX state IDLE.
- Divider:
  - Counts 0..DIVIDER_TICKS-1 and wraps.
  - Terminal count while TX is IDLE is a trigger. First trigger occurs DIVIDER_TICKS clocks after reset release.
  - Terminal count while TX is busy is dropped, not queued; the divider keeps free-running.
- On trigger: data_in is copied into a DATA_WIDTH shift register, and the byte counter is loaded with DATA_WIDTH/8.
- Byte order: data_in[DATA_WIDTH-1:DATA_WIDTH-8] is sent first, down to data_in[7:0] last.
- TX FSM states: IDLE -> START -> DATA(8 bits) -> STOP.
  - From STOP: go to START if bytes remain, else IDLE.
  - tx_out goes low on the clock after the trigger cycle.
  - Every bit lasts exactly UART_TICKS_PER_BIT clocks; data bits are sent LSB first; stop bit is 1.
  - No idle gap between consecutive bytes.
  - Full dump takes DATA_WIDTH/8 x 10 x UART_TICKS_PER_BIT clocks.
- data_in changes during a dump do not affect the bytes in flight.
- RX path:
  - 2-flop synchroniser on debug_uart_rx_in.
  - In IDLE, a falling edge (synchronised 1->0) starts a frame.
  - Start bit sampled at mid-bit (UART_TICKS_PER_BIT/2, integer division); must still be 0, else abort to IDLE with no pulse.
  - Data bits sampled every UART_TICKS_PER_BIT clocks thereafter, LSB first; then the stop bit is sampled.
- RX frame result:
  - Stop bit = 1: debug_command is loaded and debug_command_pulse=1 for exactly one clock.
  - Stop bit = 0: framing error; frame discarded, no pulse.
- RX after framing error: enter WAIT_HIGH and re-arm only after the synchronised line is seen high. A line held at 0 therefore produces at most one aborted frame and never a pulse.
- debug_command_busy is high from start-edge detection until the end of the stop-bit sample, and low in IDLE and WAIT_HIGH.
- Reset asserted mid-frame aborts TX or RX immediately. tx_out returns high asynchronously.

Optional Feature:
- Macro: DEBUGGER_CMD_RX_EN.
- Defined: RX path as described above.
- Undefined: no RX logic is built. debug_command=8'h00, debug_command_pulse=0 and debug_command_busy=0 constantly; debug_uart_rx_in is ignored. TX behaviour is unchanged.

Test Plan:
- Setup for all scenarios: DATA_WIDTH=16, DIVIDER_TICKS=15, UART_TICKS_PER_BIT=4.
- Reset hold, then release -> tx_out=1 and all command outputs 0. First start bit falls at clock 16 after release.
- data_in=16'h4c09 -> tx_out sequence, 4 clocks per bit:
  - byte 1 (0x4c): 0, 0,0,1,1,0,0,1,0, 1
  - byte 2 (0x09): 0, 1,0,0,1,0,0,0,0, 1
  - then idle high.
- Change data_in to 16'hFFFF mid-dump -> the current dump still carries 0x4c,0x09. The dropped terminal count is not queued; the next dump sends 0xFF,0xFF.
- With DEBUGGER_CMD_RX_EN defined, drive 8N1 byte 0x5A at 4 clocks/bit -> busy high during the frame; then debug_command=0x5A with debug_command_pulse high for exactly 1 clock.
- Hold debug_uart_rx_in=0 continuously -> no pulse ever; busy returns low after one aborted frame; TX dumps continue unaffected.
- Assert reset mid-byte -> tx_out=1 immediately. The dump restarts from the MSB byte after the first trigger following release.
